// File: rtl/seg_chaser_pkg.sv
// Shared encodings and ring-step helpers for the 7-segment chaser.
// Pure declarations: no state, no latency, no flow control.
package seg_chaser_pkg;

   typedef enum logic [1:0] {
      MODE_SPIN  = 2'b00,
      MODE_SNAKE = 2'b01,
      MODE_FILL  = 2'b10,
      MODE_BLINK = 2'b11
   } mode_t;

   typedef enum logic {
      PH_FILL  = 1'b0,
      PH_DRAIN = 1'b1
   } phase_t;

   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   // Logical (active-high) blank frame; output polarity is applied at the pins.
   localparam logic [7:0] SEG_OFF = 8'h00;

   function automatic logic [2:0] ring_inc(input logic [2:0] p, input int n);
      return (p == 3'(n - 1)) ? 3'd0 : p + 3'd1;
   endfunction

   function automatic logic [2:0] ring_dec(input logic [2:0] p, input int n);
      return (p == 3'd0) ? 3'(n - 1) : p - 3'd1;
   endfunction

endpackage

// File: rtl/seg_prescaler.sv
// Rate prescaler: tick is combinational while counter >= limit, paused or cleared -> no tick.
// Free-running, no backpressure; clear restarts the period from zero.
module seg_prescaler #(
   parameter int COUNTER_WIDTH = 24,
   parameter int SPEED_BITS    = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [SPEED_BITS-1:0] speed,
   input  logic                  pause,
   input  logic                  clear,
   output logic                  tick
);

   logic [COUNTER_WIDTH-1:0] counter;
   logic [COUNTER_WIDTH-1:0] limit;
   logic                     at_limit;

   // Speed sits in the limit MSBs, inverted so a larger speed gives a shorter period.
   assign limit    = {~speed, {(COUNTER_WIDTH-SPEED_BITS){1'b1}}};
   assign at_limit = (counter >= limit);
   assign tick     = !clear && !pause && at_limit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         counter <= '0;
      end else if (clear) begin
         counter <= '0;
      end else if (!pause) begin
         counter <= at_limit ? '0 : counter + 1'b1;
      end
   end

endmodule

// File: rtl/seg_chaser_multi.sv
// 7-seg ring animator (SPIN/SNAKE/FILL/BLINK) with pause, step strobe and wrap dot.
// Inputs +1 reg; new frame and step appear together 2 cycles after a tick; no backpressure.
module seg_chaser_multi
   import seg_chaser_pkg::*;
#(
   parameter int COUNTER_WIDTH = 24,
   parameter int SPEED_BITS    = 3,
   parameter int NUM_POS       = 6,
   parameter bit ACTIVE_LOW    = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [SPEED_BITS-1:0] speed,
   input  logic                  direction,
   input  logic [1:0]            mode,
   input  logic                  pause,
   output logic [7:0]            seg_out,
   output logic                  step
);

   localparam logic [7:0] POL      = ACTIVE_LOW ? 8'hFF : 8'h00;
   localparam logic [6:0] RING_ALL = 7'((1 << NUM_POS) - 1);

   logic [SPEED_BITS-1:0] speed_r;
   logic                  direction_r;
   logic                  pause_r;
   mode_t                 mode_r;
   mode_t                 mode_q;
   logic                  mode_chg;
   logic                  tick;
   logic                  tick_q;

   logic [2:0]            pos;
   logic [6:0]            mask;
   phase_t                phase;
   logic                  blink;
   logic                  dp;

   logic [2:0]            pos_nxt;
   logic [2:0]            trail;
   logic                  wrap;
   logic [6:0]            mask_upd;
   logic [6:0]            ring;
   logic [7:0]            pattern;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         speed_r     <= '0;
         direction_r <= 1'b0;
         pause_r     <= 1'b0;
         mode_r      <= MODE_SPIN;
         mode_q      <= MODE_SPIN;
      end else begin
         speed_r     <= speed;
         direction_r <= direction;
         pause_r     <= pause;
         mode_r      <= mode_t'(mode);
         mode_q      <= mode_r;
      end
   end

   assign mode_chg = (mode_r != mode_q);

   seg_prescaler #(
      .COUNTER_WIDTH (COUNTER_WIDTH),
      .SPEED_BITS    (SPEED_BITS)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .speed (speed_r),
      .pause (pause_r),
      .clear (mode_chg),
      .tick  (tick)
   );

   assign pos_nxt = direction_r ? ring_inc(pos, NUM_POS) : ring_dec(pos, NUM_POS);
   assign trail   = direction_r ? ring_dec(pos, NUM_POS) : ring_inc(pos, NUM_POS);
   assign wrap    = direction_r ? (pos == 3'(NUM_POS - 1)) : (pos == 3'd0);

   always_comb begin
      mask_upd      = mask;
      mask_upd[pos] = (phase == PH_FILL);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pos   <= '0;
         mask  <= '0;
         phase <= PH_FILL;
         blink <= 1'b0;
         dp    <= 1'b0;
      end else if (mode_chg) begin
         pos   <= '0;
         mask  <= '0;
         phase <= PH_FILL;
         blink <= 1'b0;
         dp    <= 1'b0;
      end else if (tick) begin
         pos <= pos_nxt;
         dp  <= wrap;
         if (mode_q == MODE_FILL) begin
            mask <= mask_upd;
            if (phase == PH_FILL && mask_upd == RING_ALL) begin
               phase <= PH_DRAIN;
            end else if (phase == PH_DRAIN && mask_upd == 7'd0) begin
               phase <= PH_FILL;
            end
         end
         if (mode_q == MODE_BLINK) begin
            blink <= ~blink;
         end
      end
   end

   // Pattern follows mode_q so the cycle of a mode switch never shows new-mode/old-state.
   always_comb begin
      ring = '0;
      case (mode_q)
         MODE_SPIN:  ring[pos] = 1'b1;
         MODE_SNAKE: begin
            ring[pos]   = 1'b1;
            ring[trail] = 1'b1;
         end
         MODE_FILL:  ring = mask;
         MODE_BLINK: ring = blink ? RING_ALL : 7'd0;
         default:    ring = '0;
      endcase
      pattern              = SEG_OFF;
      pattern[SEG_G:SEG_A] = ring;
      pattern[SEG_DP]      = dp;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg_out <= SEG_OFF ^ POL;
         tick_q  <= 1'b0;
         step    <= 1'b0;
      end else begin
         seg_out <= pattern ^ POL;
         tick_q  <= tick;
         step    <= tick_q;
      end
   end

endmodule

// File: tb/tb_seg_chaser_multi.sv
// Scoreboard bench: stimulus pushes expected frames from a ring-animation model, monitor pops on step.
module tb_seg_chaser_multi;

   localparam int NP = 6;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] speed;
   logic       direction;
   logic [1:0] mode;
   logic       pause;
   logic [7:0] seg_out;
   logic       step;

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];

   int       m_pos;
   bit [6:0] m_mask;
   bit       m_fill;
   bit       m_blink;
   bit       m_dp;
   bit       m_dir;
   int       m_mode;

   seg_chaser_multi #(
      .COUNTER_WIDTH (6),
      .SPEED_BITS    (3),
      .NUM_POS       (NP),
      .ACTIVE_LOW    (1'b1)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .speed     (speed),
      .direction (direction),
      .mode      (mode),
      .pause     (pause),
      .seg_out   (seg_out),
      .step      (step)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_pos   = 0;
      m_mask  = '0;
      m_fill  = 1'b1;
      m_blink = 1'b0;
      m_dp    = 1'b0;
   endfunction

   function automatic logic [7:0] model_frame();
      bit [6:0] ring;
      int trail;
      ring = '0;
      case (m_mode)
         0: ring = 7'(1 << m_pos);
         1: begin
            trail = m_dir ? (m_pos + NP - 1) % NP : (m_pos + 1) % NP;
            ring  = 7'((1 << m_pos) | (1 << trail));
         end
         2: ring = m_mask;
         default: ring = m_blink ? 7'((1 << NP) - 1) : 7'd0;
      endcase
      return ~{m_dp, ring};
   endfunction

   function automatic void model_tick();
      int nxt;
      bit wrap;
      nxt  = m_dir ? (m_pos + 1) % NP : (m_pos + NP - 1) % NP;
      wrap = m_dir ? (m_pos == NP - 1) : (m_pos == 0);
      if (m_mode == 2) begin
         m_mask[m_pos] = m_fill;
         if (m_fill && m_mask == 7'((1 << NP) - 1)) m_fill = 1'b0;
         else if (!m_fill && m_mask == 7'd0)        m_fill = 1'b1;
      end
      m_blink = !m_blink;
      m_pos   = nxt;
      m_dp    = wrap;
   endfunction

   // Drive new inputs right after a step so they govern the next tick.
   task automatic apply(input bit dir, input int md, input int spd);
      logic [7:0] rf;
      bit chg;
      chg       = (md != m_mode);
      direction = dir;
      mode      = 2'(md);
      speed     = 3'(spd);
      m_dir     = dir;
      rf        = '0;
      if (chg) begin
         model_reset();
         m_mode = md;
         rf     = model_frame();
      end
      model_tick();
      exp_q.push_back(model_frame());
      if (chg) begin
         repeat (4) @(negedge clk);
         check("mode_reset_frame", seg_out, rf);
      end
   endtask

   task automatic wait_step(input int budget, output int gap);
      gap = 0;
      do begin
         @(negedge clk);
         gap++;
      end while (!step && gap < budget);
      if (!step) begin
         n_vec++;
         n_err++;
         $display("FAIL step_timeout: no step within %0d cycles at %0t", budget, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && step) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_step: got step with seg_out 0x%0h, expected no step at %0t",
                     seg_out, $time);
         end else begin
            check("frame", seg_out, exp_q.pop_front());
         end
      end
   end

   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog: got no finish, expected finish within 60000 cycles");
      $fatal(1);
   end

   initial begin
      int gap;
      logic [7:0] cur;
      speed     = 3'd7;
      direction = 1'b1;
      mode      = 2'd0;
      pause     = 1'b0;
      #1 reset = 1'b1;
      #1;
      check("reset_seg", seg_out, 8'hFF);
      check("reset_step", step, 1'b0);
      model_reset();
      m_mode = 0;
      m_dir  = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // SPIN, first step timing and fast period
      model_tick();
      exp_q.push_back(model_frame());
      wait_step(40, gap);
      check("first_step_gap", gap, 9);
      for (int i = 0; i < 6; i++) begin
         apply(1'b1, 0, 7);
         wait_step(40, gap);
         check("spin_gap", gap, 8);
      end
      for (int i = 0; i < 7; i++) begin
         apply(1'b0, 0, 7);
         wait_step(40, gap);
      end

      // asynchronous reset in the middle of a period
      #2 reset = 1'b1;
      #1;
      check("midrun_reset_seg", seg_out, 8'hFF);
      check("midrun_reset_step", step, 1'b0);
      exp_q.delete();
      model_reset();
      m_mode    = 0;
      m_dir     = 1'b1;
      direction = 1'b1;
      mode      = 2'd0;
      speed     = 3'd7;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_tick();
      exp_q.push_back(model_frame());
      wait_step(40, gap);
      check("rereset_first_gap", gap, 9);

      // slowest rate
      apply(1'b1, 0, 0);
      wait_step(100, gap);
      apply(1'b1, 0, 0);
      wait_step(100, gap);
      check("slow_gap", gap, ((7 - 0) << 3 | 7) + 1);
      apply(1'b1, 0, 7);
      wait_step(100, gap);

      // SNAKE both directions
      for (int i = 0; i < 4; i++) begin
         apply(1'b1, 1, 7);
         wait_step(40, gap);
      end
      for (int i = 0; i < 3; i++) begin
         apply(1'b0, 1, 7);
         wait_step(40, gap);
      end

      // FILL through a full fill/drain cycle and into the refill
      for (int i = 0; i < 14; i++) begin
         apply(1'b1, 2, 7);
         wait_step(40, gap);
      end

      // pause holds everything, then resumes from the held count
      pause = 1'b1;
      cur   = model_frame();
      repeat (100) begin
         @(negedge clk);
         check("pause_hold", {step, seg_out}, {1'b0, cur});
      end
      pause = 1'b0;
      apply(1'b1, 2, 7);
      wait_step(40, gap);
      check("pause_resume_gap", gap, 8);

      // SPIN -> BLINK in mid period
      apply(1'b1, 0, 7);
      wait_step(40, gap);
      apply(1'b1, 0, 7);
      wait_step(40, gap);
      repeat (3) @(negedge clk);
      apply(1'b1, 3, 7);
      wait_step(40, gap);
      for (int i = 0; i < 7; i++) begin
         apply(1'b1, 3, 7);
         wait_step(40, gap);
      end

      // randomized direction, mode and speed
      for (int i = 0; i < 150; i++) begin
         bit dir;
         int md;
         int spd;
         dir = 1'($urandom_range(0, 1));
         md  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : m_mode;
         spd = int'($urandom_range(5, 7));
         apply(dir, md, spd);
         wait_step(100, gap);
      end

      repeat (4) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
